key_event_encoder: RTL and testbench



---
 rtl/key_event_encoder.sv | 159 +++++++++++++++
 tb/tb_key_event_encoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/key_event_encoder.sv
// key_event_encoder
// Turns the active-low raw state of a 4x4 key matrix into debounced key
// levels, then into one-at-a-time press/release events on a valid/ready
// handshake. Also provides a level "lowest pressed key" note output.
// Key index i maps to row i/4, column i%4.
module key_event_encoder #(
  parameter int unsigned SAMPLE_DIV     = 60000, // clk_in cycles per debounce sample (2..65535)
  parameter int unsigned STABLE_SAMPLES = 4      // differing samples to accept a new level (1..15)
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] key_raw,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_code,
  output logic        evt_press,
  output logic        note_active,
  output logic [3:0]  note_code
);

  localparam int unsigned NUM_KEYS = 16;

  localparam logic [15:0] TICK_LAST   = 16'(SAMPLE_DIV - 1);
  localparam logic [3:0]  STABLE_LAST = 4'(STABLE_SAMPLES - 1);

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [3:0] lowest_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [15:0] r_sync1;
  logic [15:0] r_sync2;
  logic [15:0] r_tick_cnt;
  logic [15:0] r_deb;                 // debounced level, 0 = pressed
  logic [3:0]  r_cnt [NUM_KEYS];      // per-key count of differing samples
  logic [15:0] r_reported;            // pressed state as last told to the consumer
  logic        r_evt_valid;
  logic [3:0]  r_evt_code;
  logic        r_evt_press;
  logic        r_note_active;
  logic [3:0]  r_note_code;

  // ---------------------------------------------------------------------
  // Combinational
  // ---------------------------------------------------------------------
  logic        w_tick;
  logic [15:0] w_pressed;
  logic [15:0] w_diff;
  logic        w_load;
  logic [3:0]  w_evt_idx;
  logic [3:0]  w_note_idx;

  // Derive the sample tick, pending changes and the next event to load.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    w_tick     = 1'b0;
    w_pressed  = '0;
    w_diff     = '0;
    w_load     = 1'b0;
    w_evt_idx  = '0;
    w_note_idx = '0;

    w_tick     = (r_tick_cnt == TICK_LAST);
    w_pressed  = ~r_deb;
    w_diff     = w_pressed ^ r_reported;
    w_load     = (!r_evt_valid || evt_ready) && (w_diff != '0);
    w_evt_idx  = lowest_index(w_diff);
    w_note_idx = lowest_index(w_pressed);
  end

  // Two-flop synchroniser on every raw key bit; resets to "all released".
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
    if (rst_in) begin
      r_sync1 <= 16'hFFFF;
      r_sync2 <= 16'hFFFF;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running sample divider: counts 0..SAMPLE_DIV-1 and wraps.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  // Per-key debounce: accept a new level after STABLE_SAMPLES consecutive differing ticks.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_deb <= 16'hFFFF;
      // NOTE: the per-key counters are plain flops, not a RAM, so they are reset with everything else and reset discards all debounce progress.
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (w_tick) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == STABLE_LAST) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 4'd1;
        end
      end
    end
  end

  // Event generator: report the lowest changed key whenever the slot is free or being drained.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_reported  <= '0;
      r_evt_valid <= 1'b0;
      r_evt_code  <= '0;
      r_evt_press <= 1'b0;
    end else if (w_load) begin
      r_evt_valid            <= 1'b1;
      r_evt_code             <= w_evt_idx;
      r_evt_press            <= w_pressed[w_evt_idx];
      r_reported[w_evt_idx]  <= w_pressed[w_evt_idx];
    end else if (r_evt_valid && evt_ready) begin
      // Handshake completed and nothing left to report.
      r_evt_valid <= 1'b0;
    end
  end

  // Level note output, registered from the debounced state, independent of the handshake.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_note_active <= 1'b0;
      r_note_code   <= '0;
    end else begin
      r_note_active <= |w_pressed;
      r_note_code   <= w_note_idx;
    end
  end

  assign evt_valid   = r_evt_valid;
  assign evt_code    = r_evt_code;
  assign evt_press   = r_evt_press;
  assign note_active = r_note_active;
  assign note_code   = r_note_code;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed testbench for key_event_encoder with SAMPLE_DIV=4, STABLE_SAMPLES=3.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_key_event_encoder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] key_raw;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_code;
  logic        evt_press;
  logic        note_active;
  logic [3:0]  note_code;

  int n_total = 0;
  int n_bad   = 0;

  // From reset release (key already low) to evt_valid visible:
  // sync after 2 edges, ticks on edges 4, 8, 12, deb flips on edge 12,
  // event loads on edge 13.
  localparam int LATENCY_FROM_RESET = 13;

  key_event_encoder #(
    .SAMPLE_DIV    (4),
    .STABLE_SAMPLES(3)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .key_raw    (key_raw),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_press  (evt_press),
    .note_active(note_active),
    .note_code  (note_code)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Wait (bounded) for an event, check it, then take one edge (consumes it if ready is high).
  task automatic wait_evt(input string tag, input int code, input bit press);
    int n;
    n = 0;
    while (!evt_valid && n < 60) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(evt_valid), 32'd1);
    check({tag, "_code"},  32'(evt_code),  32'(code));
    check({tag, "_press"}, 32'(evt_press), 32'(press));
    if (evt_valid) step();
  endtask

  // Count events seen over a window with ready held high.
  task automatic count_evts(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      if (evt_valid) cnt++;
      step();
    end
  endtask

  // Release reset and count edges until evt_valid appears (bounded).
  task automatic latency_after_reset(output int n);
    n = 0;
    rst_in = 1'b0;
    while (!evt_valid && n < 60) begin
      step();
      n++;
    end
  endtask

  initial begin
    int lat;
    int cnt;

    rst_in    = 1'b1;
    key_raw   = 16'hFFFE;
    evt_ready = 1'b0;

    // ---- Reset behaviour: outputs stay 0 during reset ----
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_valid",  32'(evt_valid),   32'd0);
      check("rst_code",   32'(evt_code),    32'd0);
      check("rst_press",  32'(evt_press),   32'd0);
      check("rst_nact",   32'(note_active), 32'd0);
      check("rst_ncode",  32'(note_code),   32'd0);
    end
    latency_after_reset(lat);
    check("rst_latency", 32'(lat), 32'(LATENCY_FROM_RESET));
    check("rst_ev_code",  32'(evt_code),    32'd0);
    check("rst_ev_press", 32'(evt_press),   32'd1);
    check("rst_nact_on",  32'(note_active), 32'd1);
    check("rst_ncode_on", 32'(note_code),   32'd0);
    evt_ready = 1'b1;
    wait_evt("k0_press", 0, 1'b1);
    check("k0_drained", 32'(evt_valid), 32'd0);
    key_raw = 16'hFFFF;
    wait_evt("k0_rel", 0, 1'b0);
    check("k0_nact_off", 32'(note_active), 32'd0);

    // ---- Single press / release of key 5 ----
    key_raw = ~16'h0020;
    wait_evt("k5_press", 5, 1'b1);
    check("k5_nact",  32'(note_active), 32'd1);
    check("k5_ncode", 32'(note_code),   32'd5);
    count_evts(10, cnt);
    check("k5_single", 32'(cnt), 32'd0);
    key_raw = 16'hFFFF;
    wait_evt("k5_rel", 5, 1'b0);
    check("k5_nact_off",  32'(note_active), 32'd0);
    check("k5_ncode_off", 32'(note_code),   32'd0);

    // ---- Glitch rejection: key 9 low for exactly 2 sample ticks ----
    key_raw = ~16'h0200;
    repeat (8) step();
    key_raw = 16'hFFFF;
    count_evts(40, cnt);
    check("glitch_events", 32'(cnt), 32'd0);
    check("glitch_nact",   32'(note_active), 32'd0);

    // ---- Simultaneous changes with backpressure: keys 3, 7, 12 ----
    evt_ready = 1'b0;
    key_raw   = ~16'h1088;
    wait_evt("sim_first", 3, 1'b1);  // ready low: not consumed
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(evt_valid), 32'd1);
      check("hold_code",  32'(evt_code),  32'd3);
      check("hold_press", 32'(evt_press), 32'd1);
      step();
    end
    check("sim_ncode", 32'(note_code), 32'd3);
    evt_ready = 1'b1;
    step();
    check("drain_v7",  32'(evt_valid), 32'd1);
    check("drain_c7",  32'(evt_code),  32'd7);
    step();
    check("drain_v12", 32'(evt_valid), 32'd1);
    check("drain_c12", 32'(evt_code),  32'd12);
    step();
    check("drain_end", 32'(evt_valid), 32'd0);
    key_raw = 16'hFFFF;
    wait_evt("rel3",  3,  1'b0);
    wait_evt("rel7",  7,  1'b0);
    wait_evt("rel12", 12, 1'b0);

    // ---- Net-change collapse: key 2 pressed and released while key 1 pending ----
    evt_ready = 1'b0;
    key_raw   = ~16'h0002;
    wait_evt("nc_k1", 1, 1'b1);
    key_raw = ~16'h0006;
    repeat (24) step();
    check("nc_ncode_mid", 32'(note_code), 32'd1);
    check("nc_held_code", 32'(evt_code),  32'd1);
    key_raw = ~16'h0002;
    repeat (24) step();
    evt_ready = 1'b1;
    wait_evt("nc_after", 1, 1'b1);
    count_evts(30, cnt);
    check("nc_no_k2", 32'(cnt), 32'd0);
    key_raw = 16'hFFFF;
    wait_evt("nc_rel1", 1, 1'b0);

    // ---- Reset mid-event with key 6 held ----
    evt_ready = 1'b0;
    key_raw   = ~16'h0040;
    wait_evt("mid_k6", 6, 1'b1);
    rst_in = 1'b1;
    step();
    check("mid_rst_valid", 32'(evt_valid),   32'd0);
    check("mid_rst_nact",  32'(note_active), 32'd0);
    latency_after_reset(lat);
    check("mid_latency", 32'(lat), 32'(LATENCY_FROM_RESET));
    check("mid_code",    32'(evt_code),  32'd6);
    check("mid_press",   32'(evt_press), 32'd1);
    evt_ready = 1'b1;
    step();
    key_raw = 16'hFFFF;
    wait_evt("mid_rel6", 6, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
